// File: rtl/dmem_rmw_ctrl.sv
// Data-memory read-modify-write controller in front of a synchronous word SRAM.
// Optional DMEM_FULLWORD_BYPASS_EN: full-word stores skip the SRAM read.
module dmem_rmw_ctrl #(
   parameter int DEPTH_LOG2 = 12,
   parameter int MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   input  logic                  req_r,
   input  logic                  req_w,
   input  logic                  req_full,
   output logic [31:0]           rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  sram_cs,
   output logic                  sram_we,
   output logic [DEPTH_LOG2-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]            state_q, state_d;
   logic                  is_wr_q, is_wr_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic                  one_req;
   logic                  both_req;
   logic                  bypass;

   assign one_req  = req_r ^ req_w;
   assign both_req = req_r & req_w;

`ifdef DMEM_FULLWORD_BYPASS_EN
   assign bypass = req_w & ~req_r & req_full;
   logic unused_bits;
   assign unused_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`else
   assign bypass = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{req_full, req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (one_req) begin
               addr_d  = req_addr[DEPTH_LOG2+1:2];
               is_wr_d = req_w;
               state_d = bypass ? S_WR : S_RD;
            end
         end
         S_RD: begin
            cnt_d   = 3'(MEM_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Last wait cycle: SRAM data is valid now, capture it for the port merge.
            if (cnt_q <= 3'd1) begin
               rdata_d = sram_rdata;
               cnt_d   = 3'd0;
               state_d = is_wr_q ? S_WR : S_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         is_wr_q <= 1'b0;
         cnt_q   <= 3'd0;
         rdata_q <= 32'd0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
      end
   end

   // Request-driven outputs are gated by reset so every output is low while it is held.
   assign busy       = reset & (((state_q == S_IDLE) & one_req) | (state_q == S_RD) |
                                (state_q == S_WAIT) | (state_q == S_WR));
   assign err        = reset & (state_q == S_IDLE) & both_req;
   assign done       = (state_q == S_RESP);
   assign sram_cs    = (state_q == S_RD) | (state_q == S_WR);
   assign sram_we    = (state_q == S_WR);
   assign sram_wdata = (state_q == S_WR) ? req_wdata : 32'd0;
   assign sram_addr  = addr_q;
   assign rdata      = rdata_q;

endmodule
